// File: rtl/operand_fetch_pkg.sv
// core_pkg: shared register-file types for the operand fetch path.
//   XLEN        : operand / register data width
//   REG_IDX_W   : register index width
//   reg_class_t : integer or floating-point register class
//   wr_port_t   : one register-file write port {en, idx, data}
//   bypass_hit  : true when a write port updates the named operand
package core_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    INT = 1'b0,
    FP  = 1'b1
  } reg_class_t;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } wr_port_t;

  // Integer x0 is hard-wired to zero, so a write to it never forwards.
  // FP register 0 is an ordinary register.
  function automatic logic bypass_hit(input reg_class_t           cls,
                                      input logic [REG_IDX_W-1:0] idx,
                                      input reg_class_t           port_cls,
                                      input wr_port_t             port);
    return port.en && (cls == port_cls) && (port.idx == idx) &&
           !((cls == INT) && (idx == '0));
  endfunction

endpackage

// File: rtl/operand_fetch_bypass.sv
// operand_bypass: resolves one operand against the integer and FP write
// ports. Integer x0 always yields zero; otherwise a matching write of the
// operand's class replaces the base value.
//   cls, idx : operand register class and index
//   base     : value before forwarding (register read data or held operand)
//   gport    : integer write port
//   fport    : FP write port
//   op       : resolved operand
module operand_bypass
  import core_pkg::*;
(
  input  reg_class_t           cls,
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [XLEN-1:0]      base,
  input  wr_port_t             gport,
  input  wr_port_t             fport,
  output logic [XLEN-1:0]      op
);

  always_comb begin
    op = base;
    if ((cls == INT) && (idx == '0)) begin
      op = '0;
    end else if (bypass_hit(cls, idx, INT, gport)) begin
      op = gport.data;
    end else if (bypass_hit(cls, idx, FP, fport)) begin
      op = fport.data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-file read requester between decode and execute.
// S1 holds a request whose register read is in flight (data arrives one
// cycle after the address is sampled); S2 is the output register that
// holds resolved operands under back-pressure. Write ports are snooped so
// every operand presented downstream is architecturally current.
//   clk, rstn           : clock, asynchronous active-low reset
//   flush               : kills S1 and S2 on the next edge, blocks accept
//   in_*                : decoded request (indices, FP flags, payload)
//   rgreg*/rfreg*       : integer / FP register file read addresses
//   greg_out*/freg_out* : register file read data (1-cycle latency)
//   wg*/wf*             : integer / FP register file write ports (snooped)
//   out_*               : resolved operands and payload
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid, once raised, stays high with stable payload until the
// transfer (or a flush/reset); ready may depend combinationally on the
// consumer's ready but never on the producer's valid.
module operand_fetch
  import core_pkg::*;
#(
  parameter int TAG_W = 32,
  parameter int XLEN  = core_pkg::XLEN  // must equal the register file width
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_rs1_f,
  input  logic                 in_rs2_f,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [4:0]           rgreg1,
  output logic [4:0]           rgreg2,
  output logic [4:0]           rfreg1,
  output logic [4:0]           rfreg2,
  input  logic [XLEN-1:0]      greg_out1,
  input  logic [XLEN-1:0]      greg_out2,
  input  logic [XLEN-1:0]      freg_out1,
  input  logic [XLEN-1:0]      freg_out2,
  input  logic                 wgenable,
  input  logic [4:0]           wgreg,
  input  logic [XLEN-1:0]      wgdata,
  input  logic                 wfenable,
  input  logic [4:0]           wfreg,
  input  logic [XLEN-1:0]      wfdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [TAG_W-1:0]     out_tag
);

  // S1 state
  logic                 s1_valid;
  logic [4:0]           s1_rs1, s1_rs2;
  reg_class_t           s1_cls1, s1_cls2;
  logic [TAG_W-1:0]     s1_tag;

  // S2 operand identity, kept so held operands can still be snooped
  logic [4:0]           s2_rs1, s2_rs2;
  reg_class_t           s2_cls1, s2_cls2;

  // Write ports as seen this cycle and as registered at the last edge
  wr_port_t             cur_g, cur_f;
  wr_port_t             snap_g, snap_f;

  logic                 s2_free, s1_adv, accept, s1_hold;
  logic [4:0]           rd1, rd2;
  logic [XLEN-1:0]      s1_base1, s1_base2, s1_op1, s1_op2;
  reg_class_t           nx_cls1, nx_cls2;
  logic [4:0]           nx_idx1, nx_idx2;
  logic [XLEN-1:0]      nx_base1, nx_base2, nx_op1, nx_op2;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !flush && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;

  // A stalled S1 re-reads its own indices every cycle, so the read data
  // seen by S1 always reflects the register file as of the previous edge.
  assign s1_hold = s1_valid && !s1_adv;
  assign rd1     = s1_hold ? s1_rs1 : in_rs1;
  assign rd2     = s1_hold ? s1_rs2 : in_rs2;
  assign rgreg1  = rd1;
  assign rfreg1  = rd1;
  assign rgreg2  = rd2;
  assign rfreg2  = rd2;

  assign cur_g = '{en: wgenable, idx: wgreg, data: wgdata};
  assign cur_f = '{en: wfenable, idx: wfreg, data: wfdata};

  // S1 operands: the register file returns the pre-write value when a read
  // and a write share an edge, so the write snapshot from that edge wins.
  assign s1_base1 = (s1_cls1 == FP) ? freg_out1 : greg_out1;
  assign s1_base2 = (s1_cls2 == FP) ? freg_out2 : greg_out2;

  operand_bypass u_s1_op1 (
    .cls (s1_cls1), .idx (s1_rs1), .base (s1_base1),
    .gport (snap_g), .fport (snap_f), .op (s1_op1)
  );

  operand_bypass u_s1_op2 (
    .cls (s1_cls2), .idx (s1_rs2), .base (s1_base2),
    .gport (snap_g), .fport (snap_f), .op (s1_op2)
  );

  // S2 next value: on advance, the S1 operand; while held, the current
  // output. Either way a write landing on this edge is folded in.
  assign nx_cls1  = s1_adv ? s1_cls1 : s2_cls1;
  assign nx_cls2  = s1_adv ? s1_cls2 : s2_cls2;
  assign nx_idx1  = s1_adv ? s1_rs1  : s2_rs1;
  assign nx_idx2  = s1_adv ? s1_rs2  : s2_rs2;
  assign nx_base1 = s1_adv ? s1_op1  : out_op1;
  assign nx_base2 = s1_adv ? s1_op2  : out_op2;

  operand_bypass u_s2_op1 (
    .cls (nx_cls1), .idx (nx_idx1), .base (nx_base1),
    .gport (cur_g), .fport (cur_f), .op (nx_op1)
  );

  operand_bypass u_s2_op2 (
    .cls (nx_cls2), .idx (nx_idx2), .base (nx_base2),
    .gport (cur_g), .fport (cur_f), .op (nx_op2)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_g    <= '0;
      snap_f    <= '0;
      s1_valid  <= 1'b0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_cls1   <= INT;
      s1_cls2   <= INT;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_tag   <= '0;
      s2_rs1    <= '0;
      s2_rs2    <= '0;
      s2_cls1   <= INT;
      s2_cls2   <= INT;
    end else begin
      snap_g <= cur_g;
      snap_f <= cur_f;

      if (flush) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (accept) begin
        s1_rs1  <= in_rs1;
        s1_rs2  <= in_rs2;
        s1_cls1 <= reg_class_t'(in_rs1_f);
        s1_cls2 <= reg_class_t'(in_rs2_f);
        s1_tag  <= in_tag;
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (s1_adv) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (s1_adv || (out_valid && !out_ready)) begin
        out_op1 <= nx_op1;
        out_op2 <= nx_op2;
      end

      if (s1_adv) begin
        out_tag <= s1_tag;
        s2_rs1  <= s1_rs1;
        s2_rs2  <= s1_rs2;
        s2_cls1 <= s1_cls1;
        s2_cls2 <= s1_cls2;
      end
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Requester side of the core's register-file read/write-snoop interface: accepts decoded source operands, drives the register file's read addresses and absorbs its 1-cycle synchronous read latency.
- Applies write-port bypass and holds operands under back-pressure, so downstream execute units see architecturally current values.
- Sits between decode and execute.
- Two-stage pipeline (S1 = read in flight, S2 = output hold) with valid/ready on both sides.

Parameters:
TAG_W, 32, width of opaque payload (pc/instruction/opcode) carried alongside operands
XLEN, 32, operand width; must match register file data width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of both stages
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_rs1  in  5  source 1 index
in_rs2  in  5  source 2 index
in_rs1_f  in  1  source 1 is FP register (else integer)
in_rs2_f  in  1  source 2 is FP register
in_tag  in  TAG_W  payload
rgreg1, rgreg2  out  5  integer register file read addresses
rfreg1, rfreg2  out  5  FP register file read addresses
greg_out1, greg_out2  in  XLEN  integer read data, valid one cycle after address sampled
freg_out1, freg_out2  in  XLEN  FP read data, same timing
wgenable, wgreg, wgdata  in  1/5/XLEN  integer write port (snooped)
wfenable, wfreg, wfdata  in  1/5/XLEN  FP write port (snooped)
out_valid  out  1  operands valid
out_ready  in  1  downstream accepts
out_op1, out_op2  out  XLEN  resolved operands
out_tag  out  TAG_W  payload

Behaviour:
- Reset (async, rstn=0):
  - s1_valid=0, out_valid=0.
  - out_op1/out_op2/out_tag=0.
  - Write snapshot enables=0.
  - in_ready reflects empty pipe after release.
- Handshakes:
  - s2_free = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !flush && (!s1_valid || s2_free).
- Read addresses (combinational):
  - If s1_valid && !s1_adv: drive S1's stored indices (re-read while stalled).
  - Otherwise: drive in_rs1/in_rs2.
  - rgregN and rfregN always carry the same index.
- Invariant: whenever S1 is valid, the register file sampled S1's indices at the previous edge.
- Write snapshot: every edge, register wgenable/wgreg/wgdata and wfenable/wfreg/wfdata unconditionally. The register file returns the pre-write value when a read and a write hit the same edge; the snapshot corrects this.
- S1 operand N:
  - If integer and index==0: 0.
  - Else if the snapshot of the matching class has en && reg==index: snapshot data.
  - Else greg_outN or freg_outN.
- S2 capture (s1_adv edge):
  - Register the S1 operand, then apply the current write port of the matching class (integer index 0 excluded).
  - A write on this edge wins.
- S2 hold (out_valid && !out_ready): each edge, overwrite a held operand when the matching-class write port hits its index (integer x0 excluded). Prevents stale operands after long stalls.
- FP register 0 is an ordinary register and is bypassed normally.
- Latency: accept at edge E0 gives out_valid in the cycle after E1 (2 cycles). Throughput 1/cycle with out_ready held high.
- Simultaneous events:
  - Accept and S1 advance on the same edge is allowed.
  - Both integer and FP writes on one edge are applied independently per operand class.
- flush=1:
  - On the edge, s1_valid and out_valid clear.
  - No accept that cycle.
  - Output data registers need not clear.
- Reset mid-operation: all in-flight requests dropped; no output handshake completes.

Decomposition:
- Package core_pkg:
  - XLEN=32, REG_IDX_W=5.
  - Typedef reg_class_t (INT, FP).
  - Typedef wr_port_t {en, idx, data}.
  - Function bypass_hit(cls, idx, port_cls, port) implementing the x0 exclusion.
- Sub-module operand_bypass: combinational select of register data vs write-port data for one operand; instantiated twice per stage (op1/op2).

Test Plan:
- Basic read: preload greg[5]=0x11, freg[3]=0x22; request rs1=5 int, rs2=3 fp, out_ready=1 -> out_valid two cycles later, op1=0x11, op2=0x22, tag echoed.
- Same-edge write: integer write x7=0xAB on the accepting edge, greg[7] previously 0x01, request rs1=7 -> op1=0xAB.
- x0 guard: request rs1=0 int while writing wgreg=0, wgdata=0xFFFF_FFFF -> op1=0. Same with fp rs1=0 and wfreg=0, wfdata=0x5 -> op1=0x5.
- Back-pressure: out_ready=0 for 10 cycles with S1 and S2 full, write x9=0x99 during the stall where S2 holds rs2=9 -> op2 becomes 0x99. in_ready stays 0; no request lost or duplicated after release.
- Streaming: 8 back-to-back requests, out_ready=1 -> 8 outputs on consecutive cycles in order.
- Flush/reset: flush with both stages full -> out_valid=0 next cycle, in_ready=1. Assert rstn=0 mid-stream -> out_valid drops immediately (async), out_op1=0.
